des_cbc_sched: RTL and testbench
================================

Name: des_cbc_sched

Overview:
Multi-channel CBC-mode encryption scheduler in front of the 17-cycle fully pipelined DES encrypt core. Each of NCH channels is a requester with its own key and chaining value. Grants are round-robin, at most one block per cycle. A tag pipeline tracks ownership so results return to the right channel and update its chaining value. With NCH >= LAT+2, independent CBC streams interleave and the core stays fully occupied.

Parameters:
NCH, 4, number of requester channels (1..32); CW = max(1, clog2(NCH)) is derived, not a parameter.
LAT, 17, core latency in cycles from sampled core_invalid to core_outvalid; it must match the core.

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
req_valid  in  NCH  per-channel plaintext block valid
req_data  in  NCH*64  per-channel plaintext; channel i occupies bits [64*i+63:64*i]
req_ready  out  NCH  one-hot grant; a handshake occurs when req_valid[i] && req_ready[i]
cfg_we  in  1  write key and IV for channel cfg_ch
cfg_ch  in  CW  channel to configure
cfg_key  in  64  DES key (parity bits ignored by the core)
cfg_iv  in  64  initial chaining value
cfg_err  out  1  one-cycle pulse when a cfg write is dropped
core_id  out  64  data to core (registered)
core_key  out  64  key to core (registered)
core_invalid  out  1  core input valid (registered)
core_od  in  64  core ciphertext
core_outvalid  in  1  core output valid
out_valid  out  1  ciphertext valid pulse
out_ch  out  CW  owning channel
out_data  out  64  ciphertext

Behaviour:
- Per-channel state: key[i], chain[i], busy[i]. At most one block per channel is in flight, because CBC depends on the previous ciphertext.
- Eligibility: channel i is eligible when req_valid[i] && !busy[i] && !(cfg_we && cfg_ch==i).
- Arbitration: round-robin pointer ptr.
  - Grant goes to the first eligible channel at or after ptr, wrapping modulo NCH.
  - req_ready is combinational from req_valid, busy and ptr. Upstream must not make req_valid depend on req_ready.
  - On a grant to g: ptr <= (g+1) mod NCH. With no grant, ptr holds.
- Issue (edge E0, the handshake edge for channel g):
  - core_id <= req_data[g] ^ chain[g]
  - core_key <= key[g]
  - core_invalid <= 1
  - busy[g] <= 1
  - Push tag {1, g} into the tag shift register.
- Idle cycles: core_invalid <= 0 and a tag {0, x} is pushed. core_id and core_key hold their values.
- Tag pipeline: LAT+1 stages, aligned so the tag reaches the head on the same cycle core_outvalid returns.
  - The core samples core_invalid at E1 and asserts core_outvalid after E(LAT)=E17.
- Return (edge E18 when the head tag valid bit is set, channel c):
  - out_valid <= 1, out_ch <= c, out_data <= core_od
  - chain[c] <= core_od
  - busy[c] <= 0
- Latency and throughput:
  - out_valid is high in the cycle after E18, i.e. LAT+1 = 18 cycles after the handshake edge.
  - The earliest next handshake on the same channel is E19, giving 1 block per 19 cycles per channel.
  - Aggregate throughput is 1 block per cycle once NCH >= 19 channels are all requesting.
- Output stream: no backpressure. The downstream sink must accept every out_valid pulse. out_valid is a one-cycle pulse; out_ch and out_data hold until the next return.
- Result acceptance: results are accepted only on the tag valid bit.
  - core_outvalid high without a valid tag (for example core content left over after a mid-stream reset) is ignored.
  - The bench checks that tag_valid == core_outvalid whenever neither was affected by reset.
- Configuration:
  - cfg_we to a channel that is not busy writes key and chain (IV) at the edge. The written values are used by the next grant, at the earliest the following cycle.
  - cfg_we to a busy channel is dropped, and cfg_err pulses for one cycle.
  - cfg_ch >= NCH is dropped and pulses cfg_err.
  - cfg_we and req_valid on the same channel in the same cycle: cfg wins and no grant is made that cycle.
- Reset (async assert, sync-released by the system):
  - ptr = 0; busy, chain, key = 0.
  - All tag valid bits = 0.
  - core_invalid, core_id, core_key = 0.
  - out_valid, out_ch, out_data = 0; cfg_err = 0; req_ready = 0 while rstn low.
  - Blocks in flight at reset are lost without output.

Test Plan:
- Single block: cfg ch0 key=133457799BBCDFF1, iv=0; request pt=0123456789ABCDEF -> out_valid exactly 18 cycles after the handshake, out_ch=0, out_data=85E813540F0AB405.
- CBC chaining: after the single-block scenario, ch0 pt=84CB563386A179EA -> req_ready[0] low until the return; the second handshake is no earlier than E19; out_data=85E813540F0AB405.
- Round-robin: NCH=4, all channels key=0, iv=0, pt=0, all req_valid held -> grants 0,1,2,3 on consecutive cycles, then none until the returns. Each output is 8CA64DE9C1B123A7 with out_ch 0,1,2,3 on consecutive cycles.
- Config conflicts: cfg_we to ch1 while busy[1] -> cfg_err pulse, key and IV unchanged. cfg_we to ch2 with req_valid[2] in the same cycle -> no grant to ch2 that cycle, new IV used on the next grant.
- Reset mid-flight: issue 3 blocks, drop rstn for 2 cycles at E5 -> all outputs 0 during reset, no out_valid afterwards even though the core asserts core_outvalid, ptr=0 and all channels grantable.
- Pipeline fill: NCH=20, random keys, IVs and plaintexts, all req_valid held -> core_invalid high every cycle in steady state; every out_data matches a software CBC model per channel.

Source files
------------

// File: rtl/des_cbc_sched.sv
// des_cbc_sched: round-robin multi-channel CBC scheduler in front of a pipelined DES encrypt core
module des_cbc_sched #(
    parameter int NCH = 4,
    parameter int LAT = 17,
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NCH-1:0]    req_valid,
    input  logic [NCH*64-1:0] req_data,
    output logic [NCH-1:0]    req_ready,
    input  logic              cfg_we,
    input  logic [CW-1:0]     cfg_ch,
    input  logic [63:0]       cfg_key,
    input  logic [63:0]       cfg_iv,
    output logic              cfg_err,
    output logic [63:0]       core_id,
    output logic [63:0]       core_key,
    output logic              core_invalid,
    input  logic [63:0]       core_od,
    input  logic              core_outvalid,
    output logic              out_valid,
    output logic [CW-1:0]     out_ch,
    output logic [63:0]       out_data
);
    logic [NCH-1:0][63:0] key, chain;
    logic [NCH-1:0]       busy, cfg_hit, elig, grant;
    logic [CW-1:0]        ptr, gch;
    logic                 any, cfg_ok, ret;
    logic [LAT:0]         tag_v;
    logic [LAT:0][CW-1:0] tag_c;
    int                   j;

    // eligibility, then first eligible channel at or after ptr wins
    always_comb begin
        cfg_hit = '0;
        elig = '0;
        grant = '0;
        gch = '0;
        any = 1'b0;
        j = 0;
        for (int i = 0; i < NCH; i++) begin
            cfg_hit[i] = cfg_we && (int'(cfg_ch) == i);
            elig[i] = req_valid[i] && !busy[i] && !cfg_hit[i];
        end
        for (int k = 0; k < NCH; k++) begin
            j = (int'(ptr) + k) % NCH;
            if (!any && elig[j]) begin
                any = 1'b1;
                gch = CW'(j);
                grant[j] = 1'b1;
            end
        end
    end

    assign req_ready = grant & {NCH{rstn}};
    // an out-of-range channel matches no cfg_hit bit, so it is dropped like a busy one
    assign cfg_ok = |(cfg_hit & ~busy);
    // a result counts only when a live tag reaches the head together with the core output
    assign ret = tag_v[LAT] && core_outvalid;

    // per-channel key, chaining value and in-flight flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            key <= '0;
            chain <= '0;
            busy <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (cfg_hit[i] && !busy[i]) begin
                    key[i] <= cfg_key;
                    chain[i] <= cfg_iv;
                end
                if (ret && int'(tag_c[LAT]) == i) begin
                    chain[i] <= core_od;
                    busy[i] <= 1'b0;
                end
                if (grant[i]) busy[i] <= 1'b1;
            end
        end
    end

    // arbitration pointer, registered core inputs and config drop pulse
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr <= '0;
            core_id <= '0;
            core_key <= '0;
            core_invalid <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            core_invalid <= any;
            cfg_err <= cfg_we && !cfg_ok;
            if (any) begin
                ptr <= (int'(gch) == NCH - 1) ? '0 : gch + 1'b1;
                core_id <= req_data[64*int'(gch) +: 64] ^ chain[gch];
                core_key <= key[gch];
            end
        end
    end

    // ownership tags travel in lockstep with the core pipeline
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tag_v <= '0;
            tag_c <= '0;
        end else begin
            tag_v <= {tag_v[LAT-1:0], any};
            tag_c <= {tag_c[LAT-1:0], gch};
        end
    end

    // capture the returning ciphertext for the owning channel
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_ch <= '0;
            out_data <= '0;
        end else begin
            out_valid <= ret;
            if (ret) begin
                out_ch <= tag_c[LAT];
                out_data <= core_od;
            end
        end
    end
endmodule

// File: tb/tb_des_cbc_sched.sv
// tb_des_cbc_sched: scoreboard bench for des_cbc_sched with a 17-stage core stand-in
module tb_des_cbc_sched;
    localparam int LAT = 17;
    typedef struct { int ch; logic [63:0] d; int hs; } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int cyc = 0;
    int checks = 0;
    int fails = 0;
    int cov4 = 0;
    int ov4 = 0;
    exp_t q4[$];
    exp_t q20[$];
    exp_t e4, e20;
    logic [63:0] mk4 [4];
    logic [63:0] mc4 [4];
    logic [63:0] mk20 [20];
    logic [63:0] mc20 [20];

    logic [3:0]   req_valid = '0;
    logic [255:0] req_data = '0;
    logic         cfg_we = 1'b0;
    logic [1:0]   cfg_ch = '0;
    logic [63:0]  cfg_key = '0;
    logic [63:0]  cfg_iv = '0;
    logic [3:0]   req_ready;
    logic         cfg_err, core_invalid, core_outvalid, out_valid;
    logic [63:0]  core_id, core_key, core_od, out_data;
    logic [1:0]   out_ch;

    logic [19:0]   rv20 = '0;
    logic [1279:0] rd20 = '0;
    logic          cwe20 = 1'b0;
    logic [4:0]    cch20 = '0;
    logic [63:0]   ck20 = '0;
    logic [63:0]   civ20 = '0;
    logic [19:0]   rr20;
    logic          cerr20, cinv20, cov20, ov20;
    logic [63:0]   cid20, ckey20, cod20, od20;
    logic [4:0]    och20;

    logic [LAT-1:0] cv4 = '0;
    logic [LAT-1:0] cv20 = '0;
    logic [63:0]    cd4 [LAT];
    logic [63:0]    cd20 [LAT];

    des_cbc_sched #(.NCH(4), .LAT(LAT)) u4 (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_key(cfg_key), .cfg_iv(cfg_iv), .cfg_err(cfg_err),
        .core_id(core_id), .core_key(core_key), .core_invalid(core_invalid),
        .core_od(core_od), .core_outvalid(core_outvalid),
        .out_valid(out_valid), .out_ch(out_ch), .out_data(out_data)
    );

    des_cbc_sched #(.NCH(20), .LAT(LAT)) u20 (
        .clk(clk), .rstn(rstn), .req_valid(rv20), .req_data(rd20), .req_ready(rr20),
        .cfg_we(cwe20), .cfg_ch(cch20), .cfg_key(ck20), .cfg_iv(civ20), .cfg_err(cerr20),
        .core_id(cid20), .core_key(ckey20), .core_invalid(cinv20),
        .core_od(cod20), .core_outvalid(cov20),
        .out_valid(ov20), .out_ch(och20), .out_data(od20)
    );

    // Known DES pairs are returned exactly; anything else gets a deterministic stand-in mix.
    function automatic logic [63:0] core_fn(input logic [63:0] d, input logic [63:0] k);
        if (k == 64'h133457799BBCDFF1 && d == 64'h0123456789ABCDEF) return 64'h85E813540F0AB405;
        if (k == 64'h0 && d == 64'h0) return 64'h8CA64DE9C1B123A7;
        return {d[31:0] ^ k[63:32], d[63:32] + k[31:0]} ^ 64'h0F1E2D3C4B5A6978;
    endfunction

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        cv4 <= {cv4[LAT-2:0], core_invalid};
        cd4[0] <= core_fn(core_id, core_key);
        for (int k = 1; k < LAT; k++) cd4[k] <= cd4[k-1];
    end
    assign core_outvalid = cv4[LAT-1];
    assign core_od = cd4[LAT-1];

    always @(posedge clk) begin
        cv20 <= {cv20[LAT-2:0], cinv20};
        cd20[0] <= core_fn(cid20, ckey20);
        for (int k = 1; k < LAT; k++) cd20[k] <= cd20[k-1];
    end
    assign cov20 = cv20[LAT-1];
    assign cod20 = cd20[LAT-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) if (core_outvalid) cov4 <= cov4 + 1;

    always @(negedge clk) begin
        if (out_valid) begin
            ov4 <= ov4 + 1;
            if (q4.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL out4_unexpected: got out_valid on ch %0d, expected no output", out_ch);
            end else begin
                e4 = q4.pop_front();
                chk("out4_ch", 64'(out_ch), 64'(e4.ch));
                chk("out4_data", out_data, e4.d);
                chk("out4_latency", 64'(cyc - e4.hs), 64'd18);
            end
        end
    end

    always @(negedge clk) begin
        if (ov20) begin
            if (q20.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL out20_unexpected: got out_valid on ch %0d, expected no output", och20);
            end else begin
                e20 = q20.pop_front();
                chk("out20_ch", 64'(och20), 64'(e20.ch));
                chk("out20_data", od20, e20.d);
                chk("out20_latency", 64'(cyc - e20.hs), 64'd18);
            end
        end
    end

    task automatic send4(input int ch, input logic [63:0] pt, output int hs);
        int n;
        logic [63:0] e;
        n = 0;
        req_data[64*ch +: 64] = pt;
        req_valid[ch] = 1'b1;
        #1;
        while (!req_ready[ch] && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        hs = cyc + 1;
        if (n >= 200) begin
            checks++;
            fails++;
            $display("FAIL send4_grant ch%0d: got no grant in 200 cycles, expected a grant", ch);
        end else begin
            e = core_fn(pt ^ mc4[ch], mk4[ch]);
            mc4[ch] = e;
            q4.push_back('{ch, e, cyc + 1});
        end
        @(posedge clk);
        #1 req_valid[ch] = 1'b0;
    endtask

    task automatic cfg4(input int ch, input logic [63:0] k, input logic [63:0] iv, input logic err);
        @(negedge clk);
        cfg_we = 1'b1;
        cfg_ch = 2'(ch);
        cfg_key = k;
        cfg_iv = iv;
        @(posedge clk);
        #1 cfg_we = 1'b0;
        chk("cfg4_err", 64'(cfg_err), 64'(err));
        if (!err) begin
            mk4[ch] = k;
            mc4[ch] = iv;
        end
    endtask

    task automatic drain4();
        int n;
        n = 0;
        while (q4.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain4_empty", 64'(q4.size()), 64'd0);
    endtask

    task automatic rst_checks(input string t);
        req_valid = 4'hF;
        #1;
        chk({t, "_ready"}, 64'(req_ready), 64'd0);
        chk({t, "_core_invalid"}, 64'(core_invalid), 64'd0);
        chk({t, "_core_id"}, core_id, 64'd0);
        chk({t, "_core_key"}, core_key, 64'd0);
        chk({t, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({t, "_out_ch"}, 64'(out_ch), 64'd0);
        chk({t, "_out_data"}, out_data, 64'd0);
        chk({t, "_cfg_err"}, 64'(cfg_err), 64'd0);
        req_valid = '0;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got no end of test, expected finish within 300000 ns");
        $fatal(1);
    end

    initial begin
        int h1, h2, cov_mark, ov_mark, gaps, blocks, n;
        int hr [4];
        logic [19:0] hsv;
        logic [63:0] k, v, ev;
        foreach (mk4[i]) begin mk4[i] = '0; mc4[i] = '0; end
        foreach (mk20[i]) begin mk20[i] = '0; mc20[i] = '0; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rv20 = '1;
        rst_checks("rst");
        chk("rst_ready20", 64'(rr20), 64'd0);
        rv20 = '0;
        @(negedge clk);
        rstn = 1'b1;

        // single block, then a chained second block held valid while the first is in flight
        cfg4(0, 64'h133457799BBCDFF1, 64'h0, 1'b0);
        send4(0, 64'h0123456789ABCDEF, h1);
        send4(0, 64'h84CB563386A179EA, h2);
        chk("cbc_handshake_gap", 64'(h2 - h1), 64'd19);
        drain4();
        chk("cbc_out_data", out_data, 64'h85E813540F0AB405);
        chk("cbc_out_ch", 64'(out_ch), 64'd0);

        // config write to a busy channel is dropped
        send4(1, 64'h0, h1);
        cfg4(1, 64'hFEDCBA9876543210, 64'h1111111111111111, 1'b1);
        drain4();
        send4(1, 64'h2222222222222222, h1);
        drain4();

        // config and request on the same channel in the same cycle: config wins
        @(negedge clk);
        cfg_we = 1'b1;
        cfg_ch = 2'd2;
        cfg_key = 64'h0123456789ABCDEF;
        cfg_iv = 64'h5555AAAA5555AAAA;
        req_data[128 +: 64] = 64'h3333333333333333;
        req_valid[2] = 1'b1;
        #1;
        chk("cfg_same_cycle_ready2", 64'(req_ready[2]), 64'd0);
        @(posedge clk);
        #1 cfg_we = 1'b0;
        chk("cfg_same_cycle_err", 64'(cfg_err), 64'd0);
        mk4[2] = 64'h0123456789ABCDEF;
        mc4[2] = 64'h5555AAAA5555AAAA;
        send4(2, 64'h3333333333333333, h1);
        drain4();

        // reset with three blocks in flight
        fork
            send4(0, 64'h3, hr[0]);
            send4(1, 64'h4, hr[1]);
            send4(3, 64'h5, hr[3]);
        join
        repeat (3) @(posedge clk);
        #1 rstn = 1'b0;
        q4.delete();
        cov_mark = cov4;
        ov_mark = ov4;
        foreach (mk4[i]) begin mk4[i] = '0; mc4[i] = '0; end
        @(negedge clk);
        rst_checks("midrst");
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_valid = 4'(1 << i);
            #1;
            chk("midrst_grantable", 64'(req_ready), 64'(1 << i));
        end
        req_valid = '0;
        @(negedge clk);
        req_valid = 4'hF;
        #1;
        chk("midrst_ptr_zero", 64'(req_ready), 64'd1);
        req_valid = '0;
        repeat (30) @(negedge clk);
        chk("midrst_core_returns", 64'(cov4 - cov_mark), 64'd3);
        chk("midrst_no_output", 64'(ov4 - ov_mark), 64'd0);

        // round robin across all four channels with zero key, IV and plaintext
        for (int i = 0; i < 4; i++) cfg4(i, 64'h0, 64'h0, 1'b0);
        fork
            send4(0, 64'h0, hr[0]);
            send4(1, 64'h0, hr[1]);
            send4(2, 64'h0, hr[2]);
            send4(3, 64'h0, hr[3]);
        join
        for (int i = 1; i < 4; i++) chk("rr_grant_order", 64'(hr[i] - hr[0]), 64'(i));
        drain4();
        chk("rr_out_data", out_data, 64'h8CA64DE9C1B123A7);
        chk("rr_out_ch", 64'(out_ch), 64'd3);

        // twenty channels, random keys, IVs and plaintexts, all requesting
        for (int i = 0; i < 20; i++) begin
            k = {$urandom, $urandom};
            v = {$urandom, $urandom};
            @(negedge clk);
            cwe20 = 1'b1;
            cch20 = 5'(i);
            ck20 = k;
            civ20 = v;
            @(posedge clk);
            #1 cwe20 = 1'b0;
            chk("cfg20_err", 64'(cerr20), 64'd0);
            mk20[i] = k;
            mc20[i] = v;
        end
        @(negedge clk);
        cwe20 = 1'b1;
        cch20 = 5'd25;
        @(posedge clk);
        #1 cwe20 = 1'b0;
        chk("cfg20_out_of_range_err", 64'(cerr20), 64'd1);
        for (int i = 0; i < 20; i++) rd20[64*i +: 64] = {$urandom, $urandom};
        rv20 = '1;
        gaps = 0;
        blocks = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            #1;
            if (c >= 1 && !cinv20) gaps++;
            hsv = rv20 & rr20;
            for (int i = 0; i < 20; i++) begin
                if (hsv[i]) begin
                    ev = core_fn(rd20[64*i +: 64] ^ mc20[i], mk20[i]);
                    mc20[i] = ev;
                    q20.push_back('{i, ev, cyc + 1});
                    blocks++;
                end
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < 20; i++) if (hsv[i]) rd20[64*i +: 64] = {$urandom, $urandom};
        end
        rv20 = '0;
        n = 0;
        while (q20.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("fill_core_gaps", 64'(gaps), 64'd0);
        chk("fill_blocks", 64'(blocks), 64'd200);
        chk("fill_drain_empty", 64'(q20.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
